// File: rtl/projection_router_pkg.sv
// Shared widths, projection-word field offsets and VM decode for the projection router.
package projection_router_pkg;

  localparam int unsigned PHI_BITS   = 14;
  localparam int unsigned Z_BITS     = 12;
  localparam int unsigned PHID_BITS  = 9;
  localparam int unsigned ZD_BITS    = 9;
  localparam int unsigned TKL_BITS   = 10;
  localparam int unsigned ENTRY_BITS = 6;
  localparam int unsigned BX_BITS    = 3;
  localparam int unsigned NUM_VM     = 8;

  localparam int unsigned VM_BITS    = 3;
  localparam int unsigned CNT_BITS   = ENTRY_BITS + 1;
  localparam int unsigned ADDR_BITS  = BX_BITS + ENTRY_BITS;
  localparam int unsigned PROJ_BITS  = TKL_BITS + PHI_BITS + Z_BITS + PHID_BITS + ZD_BITS;

  localparam int unsigned ZD_LSB     = 0;
  localparam int unsigned PHID_LSB   = ZD_LSB + ZD_BITS;
  localparam int unsigned Z_LSB      = PHID_LSB + PHID_BITS;
  localparam int unsigned PHI_LSB    = Z_LSB + Z_BITS;
  localparam int unsigned TKL_LSB    = PHI_LSB + PHI_BITS;

  // Two coarse phi bits select the region, the z sign bit selects the half.
  function automatic logic [VM_BITS-1:0] vm_index(input logic [PHI_BITS-1:0] phi,
                                                  input logic [Z_BITS-1:0]   z);
    return {phi[PHI_BITS-1 -: 2], z[Z_BITS-1]};
  endfunction

endpackage

// File: rtl/projection_router_vm_entry_counter.sv
// Per-VM saturating entry counter with sticky overflow flag for the current event.
module vm_entry_counter
  import projection_router_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                clr,
  output logic [CNT_BITS-1:0] count,
  output logic                full,
  output logic                ovf
);

  localparam logic [CNT_BITS-1:0] CAPACITY = CNT_BITS'(1 << ENTRY_BITS);

  assign full = (count == CAPACITY);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      // A write coinciding with clr is the first entry of the new event.
      count <= {{(CNT_BITS-1){1'b0}}, inc};
      ovf   <= 1'b0;
    end else if (inc) begin
      if (full) ovf   <= 1'b1;
      else      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/projection_router.sv
// Routes each projection word to its VM memory at {bx, entry} and reports per-VM counts at event boundaries.
module projection_router
  import projection_router_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [PROJ_BITS-1:0]          projection_in,
  input  logic                          proj_wr_en,
  output logic [PROJ_BITS-1:0]          proj_out,
  output logic [NUM_VM-1:0]             vm_wr_en,
  output logic [ADDR_BITS-1:0]          vm_wr_addr,
  output logic [NUM_VM*CNT_BITS-1:0]    nproj_out,
  output logic [NUM_VM-1:0]             overflow
);

  logic [BX_BITS-1:0]          bx;
  logic [BX_BITS-1:0]          bx_next;
  logic [VM_BITS-1:0]          vm;
  logic [CNT_BITS-1:0]         cnt [NUM_VM];
  logic [NUM_VM-1:0]           full;
  logic [NUM_VM-1:0]           ovf;
  logic [NUM_VM*CNT_BITS-1:0]  cnt_packed;
  logic                        accept;
  logic [BX_BITS-1:0]          wr_bx;
  logic [ENTRY_BITS-1:0]       wr_entry;

  assign bx_next = bx + 1'b1;
  assign vm      = vm_index(projection_in[PHI_LSB +: PHI_BITS], projection_in[Z_LSB +: Z_BITS]);

  for (genvar k = 0; k < NUM_VM; k++) begin : g_vm
    vm_entry_counter u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (proj_wr_en && (vm == VM_BITS'(k))),
      .clr   (start),
      .count (cnt[k]),
      .full  (full[k]),
      .ovf   (ovf[k])
    );
  end

  always_comb begin
    cnt_packed = '0;
    for (int unsigned k = 0; k < NUM_VM; k++) begin
      cnt_packed[k*CNT_BITS +: CNT_BITS] = cnt[k];
    end
  end

  // A start-cycle write targets the freshly cleared page of the next event.
  always_comb begin
    accept   = proj_wr_en && (start || !full[vm]);
    wr_bx    = start ? bx_next : bx;
    wr_entry = start ? '0 : cnt[vm][ENTRY_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bx         <= '0;
      proj_out   <= '0;
      vm_wr_en   <= '0;
      vm_wr_addr <= '0;
      nproj_out  <= '0;
      overflow   <= '0;
    end else begin
      vm_wr_en <= '0;
      if (proj_wr_en) proj_out <= projection_in;
      if (accept) begin
        vm_wr_en[vm] <= 1'b1;
        vm_wr_addr   <= {wr_bx, wr_entry};
      end
      if (start) begin
        nproj_out <= cnt_packed;
        overflow  <= ovf;
        bx        <= bx_next;
      end
    end
  end

endmodule

// File: tb/tb_projection_router.sv
// Directed and randomized checks of projection_router against an event-level reference model.
module tb_projection_router;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        proj_wr_en = 1'b0;
  logic [53:0] projection_in = '0;
  logic [53:0] proj_out;
  logic [7:0]  vm_wr_en;
  logic [8:0]  vm_wr_addr;
  logic [55:0] nproj_out;
  logic [7:0]  overflow;

  int n_checks = 0;
  int n_fail   = 0;

  int   m_cnt [8];
  bit   m_ovf [8];
  int   m_bx;
  logic [53:0] e_proj;
  logic [7:0]  e_en;
  logic [8:0]  e_addr;
  logic [55:0] e_nproj;
  logic [7:0]  e_ovf;
  bit          chk_on = 0;

  always #5 clk = ~clk;

  projection_router dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .projection_in (projection_in),
    .proj_wr_en    (proj_wr_en),
    .proj_out      (proj_out),
    .vm_wr_en      (vm_wr_en),
    .vm_wr_addr    (vm_wr_addr),
    .nproj_out     (nproj_out),
    .overflow      (overflow)
  );

  function automatic logic [53:0] mk(input logic [13:0] phi, input logic [11:0] z);
    logic [9:0] tkl;
    logic [8:0] pd;
    logic [8:0] zd;
    tkl = 10'($urandom);
    pd  = 9'($urandom);
    zd  = 9'($urandom);
    return {tkl, phi, z, pd, zd};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Event-level model: one clock edge with the given inputs.
  task automatic model_edge(input bit r, input bit s, input bit w, input logic [53:0] p);
    int vm;
    if (r) begin
      m_bx = 0;
      for (int k = 0; k < 8; k++) begin m_cnt[k] = 0; m_ovf[k] = 0; end
      e_proj = '0; e_en = '0; e_addr = '0; e_nproj = '0; e_ovf = '0;
      return;
    end
    e_en = '0;
    if (s) begin
      for (int k = 0; k < 8; k++) begin
        e_nproj[k*7 +: 7] = 7'(m_cnt[k]);
        e_ovf[k]          = m_ovf[k];
        m_cnt[k] = 0;
        m_ovf[k] = 0;
      end
      m_bx = (m_bx + 1) % 8;
    end
    if (w) begin
      vm = int'(p[43:42]) * 2 + int'(p[29]);
      e_proj = p;
      if (m_cnt[vm] < 64) begin
        e_en[vm] = 1'b1;
        e_addr   = 9'(m_bx * 64 + m_cnt[vm]);
        m_cnt[vm]++;
      end else begin
        m_ovf[vm] = 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit w, input logic [53:0] p);
    reset = r; start = s; proj_wr_en = w; projection_in = p;
    @(posedge clk);
    model_edge(r, s, w, p);
    chk_on = 1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("proj_out",   64'(proj_out),   64'(e_proj));
      chk("vm_wr_en",   64'(vm_wr_en),   64'(e_en));
      chk("vm_wr_addr", 64'(vm_wr_addr), 64'(e_addr));
      chk("nproj_out",  64'(nproj_out),  64'(e_nproj));
      chk("overflow",   64'(overflow),   64'(e_ovf));
    end
  end

  logic [53:0] w;
  int unsigned rr;

  initial begin
    // Reset state
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);
    chk("rst_en",    64'(vm_wr_en),   64'h0);
    chk("rst_nproj", 64'(nproj_out),  64'h0);
    chk("rst_proj",  64'(proj_out),   64'h0);

    // Single write to VM 6
    w = mk(14'h3000, 12'h010);
    cyc(0, 0, 1, w);
    chk("vm6_en",   64'(vm_wr_en),   64'h40);
    chk("vm6_addr", 64'(vm_wr_addr), 64'h000);
    chk("vm6_proj", 64'(proj_out),   64'(w));
    cyc(0, 0, 0, '0);
    chk("idle_en",   64'(vm_wr_en),   64'h0);
    chk("idle_proj", 64'(proj_out),   64'(w));

    // Three back-to-back writes to VM 1
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, mk(14'h0000, 12'h800));
      chk("vm1_en",   64'(vm_wr_en),   64'h02);
      chk("vm1_addr", 64'(vm_wr_addr), 64'(i));
    end
    cyc(0, 1, 0, '0);
    chk("vm1_nproj", 64'(nproj_out[13:7]),  64'd3);
    chk("vm6_nproj", 64'(nproj_out[48:42]), 64'd1);

    // 65 writes to VM 0 in event bx=1
    for (int i = 0; i < 65; i++) begin
      cyc(0, 0, 1, mk(14'h0123, 12'h055));
      if (i < 64) begin
        chk("vm0_en",   64'(vm_wr_en),   64'h01);
        chk("vm0_addr", 64'(vm_wr_addr), 64'(64 + i));
      end else begin
        chk("vm0_drop", 64'(vm_wr_en),   64'h00);
      end
    end
    cyc(0, 1, 0, '0);
    chk("vm0_ovf",   64'(overflow[0]),     64'd1);
    chk("vm0_nproj", 64'(nproj_out[6:0]),  64'd64);
    cyc(0, 0, 0, '0);
    chk("stable_nproj", 64'(nproj_out[6:0]), 64'd64);

    // start coinciding with a VM 2 write, bx=0
    cyc(1, 0, 0, '0);
    cyc(0, 1, 1, mk(14'h1000, 12'h000));
    chk("vm2_en",    64'(vm_wr_en),         64'h04);
    chk("vm2_addr",  64'(vm_wr_addr),       64'h040);
    chk("vm2_excl",  64'(nproj_out[20:14]), 64'd0);
    cyc(0, 1, 0, '0);
    chk("vm2_next",  64'(nproj_out[20:14]), 64'd1);

    // bx wrap after eight empty events
    cyc(1, 0, 0, '0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, '0);
    cyc(0, 0, 1, mk(14'h2000, 12'hF00));
    chk("wrap_en", 64'(vm_wr_en),        64'h20);
    chk("wrap_bx", 64'(vm_wr_addr[8:6]), 64'd0);

    // Reset mid-event after five writes
    cyc(0, 1, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, mk(14'(i) << 12, 12'h000));
    cyc(1, 0, 0, '0);
    chk("mid_en",    64'(vm_wr_en),   64'h0);
    chk("mid_addr",  64'(vm_wr_addr), 64'h0);
    chk("mid_nproj", 64'(nproj_out),  64'h0);
    chk("mid_ovf",   64'(overflow),   64'h0);
    chk("mid_proj",  64'(proj_out),   64'h0);
    cyc(0, 0, 1, mk(14'h0000, 12'h000));
    chk("mid_next", 64'(vm_wr_addr), 64'h000);

    // Randomized traffic, skewed toward VM 0 so it overflows now and then
    for (int i = 0; i < 3000; i++) begin
      logic [13:0] phi;
      logic [11:0] z;
      rr  = $urandom_range(0, 999);
      phi = 14'($urandom);
      z   = 12'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        phi[13:12] = 2'b00;
        z[11]      = 1'b0;
      end
      cyc(rr < 3, $urandom_range(0, 99) < 1, $urandom_range(0, 99) < 70, mk(phi, z));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
